// File: rtl/rsa_job_sequencer.sv
// RSA job sequencer: key generation, round-robin enc/dec grant,
// mod-exp engine control, response hold and engine timeout.
module rsa_job_sequencer #(
  parameter int WIDTH   = 256,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_start,
  output logic               key_ready,
  input  logic               req_enc,
  input  logic [WIDTH-1:0]   enc_msg,
  output logic               gnt_enc,
  input  logic               req_dec,
  input  logic [WIDTH-1:0]   dec_msg,
  output logic               gnt_dec,
  output logic               inv_reset,
  input  logic               inv_finish,
  output logic               exp_reset,
  input  logic               exp_finish,
  input  logic [2*WIDTH-1:0] exp_result,
  output logic [2*WIDTH-1:0] exp_base,
  output logic               encrypt_decrypt,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  input  logic               rsp_ready,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    NOKEY, KEY_RST, KEYGEN, READY, EXP_RST, RUN, RESP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          rst_ph;
  logic          prio_dec;
  logic          pick_enc, pick_dec;
  logic          cnt_hit;
  logic          tmo;

  // prio_dec set means enc won last time, so dec wins a tie
  assign pick_enc = req_enc & (~req_dec | ~prio_dec);
  assign pick_dec = req_dec & ~pick_enc;
  assign cnt_hit  = (cnt == LIM);
  assign tmo      = cnt_hit &
                    (((state == KEYGEN) & ~inv_finish) |
                     ((state == RUN) & ~exp_finish));

  always_comb begin
    state_n   = state;
    inv_reset = 1'b1;
    exp_reset = 1'b1;
    gnt_enc   = 1'b0;
    gnt_dec   = 1'b0;
    key_ready = 1'b0;
    busy      = 1'b1;
    unique case (state)
      NOKEY: begin
        busy = 1'b0;
        if (key_start) state_n = KEY_RST;
      end
      KEY_RST: state_n = KEYGEN;
      KEYGEN: begin
        inv_reset = 1'b0;
        if (inv_finish)   state_n = READY;
        else if (cnt_hit) state_n = NOKEY;
      end
      READY: begin
        key_ready = 1'b1;
        busy      = 1'b0;
        if (key_start) begin
          state_n = KEY_RST;
        end else if (pick_enc) begin
          gnt_enc = 1'b1;
          state_n = EXP_RST;
        end else if (pick_dec) begin
          gnt_dec = 1'b1;
          state_n = EXP_RST;
        end
      end
      EXP_RST: begin
        key_ready = 1'b1;
        if (rst_ph) state_n = RUN;
      end
      RUN: begin
        key_ready = 1'b1;
        exp_reset = 1'b0;
        if (exp_finish)   state_n = RESP;
        else if (cnt_hit) state_n = READY;
      end
      RESP: begin
        key_ready = 1'b1;
        if (rsp_ready) state_n = READY;
      end
      default: state_n = NOKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= NOKEY;
      cnt             <= '0;
      rst_ph          <= 1'b0;
      prio_dec        <= 1'b0;
      exp_base        <= '0;
      encrypt_decrypt <= 1'b0;
      rsp_id          <= 1'b0;
      rsp_data        <= '0;
      rsp_valid       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state  <= state_n;
      rst_ph <= (state == EXP_RST) ? ~rst_ph : 1'b0;
      if ((state == KEYGEN) || (state == RUN)) begin
        if (cnt != SAT) cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
      if (gnt_enc) begin
        prio_dec        <= 1'b1;
        exp_base        <= (2*WIDTH)'(enc_msg);
        encrypt_decrypt <= 1'b1;
        rsp_id          <= 1'b1;
      end else if (gnt_dec) begin
        prio_dec        <= 1'b0;
        exp_base        <= (2*WIDTH)'(dec_msg);
        encrypt_decrypt <= 1'b0;
        rsp_id          <= 1'b0;
      end
      if ((state == RUN) && exp_finish) begin
        rsp_data  <= exp_result;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if ((state_n == KEY_RST) && (state != KEY_RST))
        timeout_err <= 1'b0;
      else if (tmo)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Bench for rsa_job_sequencer: job table with response scoreboard,
// plus keygen, timeout and mid-job reset sequences.
module tb_rsa_job_sequencer;

  localparam int W = 16;
  localparam logic [31:0] KE = 32'hE1E1_0000;
  localparam logic [31:0] KD = 32'h0000_D2D2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic key_start = 0, req_enc = 0, req_dec = 0;
  logic inv_finish = 0, exp_finish = 0, rsp_ready = 0;
  logic [W-1:0] enc_msg = '0, dec_msg = '0;
  logic [2*W-1:0] exp_result = '0;
  logic key_ready, gnt_enc, gnt_dec, inv_reset, exp_reset;
  logic encrypt_decrypt, rsp_valid, rsp_id, busy, timeout_err;
  logic [2*W-1:0] exp_base, rsp_data;

  logic t_key_start = 0, t_req_enc = 0, t_req_dec = 0;
  logic t_inv_finish = 0, t_exp_finish = 0, t_rsp_ready = 1;
  logic t_key_ready, t_gnt_enc, t_gnt_dec, t_inv_reset, t_exp_reset;
  logic t_encrypt_decrypt, t_rsp_valid, t_rsp_id, t_busy, t_timeout_err;
  logic [2*W-1:0] t_exp_base, t_rsp_data;

  rsa_job_sequencer #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .key_start(key_start),
    .key_ready(key_ready), .req_enc(req_enc), .enc_msg(enc_msg),
    .gnt_enc(gnt_enc), .req_dec(req_dec), .dec_msg(dec_msg),
    .gnt_dec(gnt_dec), .inv_reset(inv_reset), .inv_finish(inv_finish),
    .exp_reset(exp_reset), .exp_finish(exp_finish),
    .exp_result(exp_result), .exp_base(exp_base),
    .encrypt_decrypt(encrypt_decrypt), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  rsa_job_sequencer #(.WIDTH(W), .TIMEOUT(8)) dut8 (
    .clk(clk), .reset(reset), .key_start(t_key_start),
    .key_ready(t_key_ready), .req_enc(t_req_enc), .enc_msg(enc_msg),
    .gnt_enc(t_gnt_enc), .req_dec(t_req_dec), .dec_msg(dec_msg),
    .gnt_dec(t_gnt_dec), .inv_reset(t_inv_reset),
    .inv_finish(t_inv_finish), .exp_reset(t_exp_reset),
    .exp_finish(t_exp_finish), .exp_result(exp_result),
    .exp_base(t_exp_base), .encrypt_decrypt(t_encrypt_decrypt),
    .rsp_valid(t_rsp_valid), .rsp_id(t_rsp_id), .rsp_data(t_rsp_data),
    .rsp_ready(t_rsp_ready), .busy(t_busy),
    .timeout_err(t_timeout_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } rsp_t;
  rsp_t sbq[$];
  rsp_t mon_e;

  typedef struct {
    bit          re;
    bit          rd;
    logic [15:0] me;
    logic [15:0] md;
    int          lat;
    int          hold;
    bit          exp_enc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] m,
                                        input bit enc);
    return (32'(m) * 32'd3) ^ (enc ? KE : KD);
  endfunction

  always @(posedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0h, required none",
                 rsp_id, rsp_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
      end
    end
    if (reset && t_rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL t_rsp_unexpected: got rsp_valid=1, required 0");
    end
  end

  task automatic wait_gnt(output bit got);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      if (gnt_enc || gnt_dec) got = 1;
      else @(negedge clk);
    end
  endtask

  task automatic dut_keygen(input int lat);
    int low;
    low = 0;
    @(negedge clk) key_start = 1;
    @(negedge clk) key_start = 0;
    chk("keyrst_inv_reset", 64'(inv_reset), 1);
    chk("keyrst_busy", 64'(busy), 1);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (!inv_reset) low++;
      if (i == lat - 1) inv_finish = 1;
    end
    @(negedge clk) inv_finish = 0;
    chk("keygen_low_cycles", 64'(low), 64'(lat));
    chk("key_ready", 64'(key_ready), 1);
    chk("ready_inv_reset", 64'(inv_reset), 1);
  endtask

  task automatic do_job(input vec_t v);
    bit got;
    logic [31:0] d;
    @(negedge clk);
    req_enc = v.re;
    req_dec = v.rd;
    enc_msg = v.me;
    dec_msg = v.md;
    wait_gnt(got);
    chk("grant_seen", 64'(got), 1);
    if (!got) begin
      req_enc = 0;
      req_dec = 0;
      return;
    end
    chk("gnt_pair", 64'({gnt_enc, gnt_dec}), v.exp_enc ? 64'd2 : 64'd1);
    d = model(v.exp_enc ? v.me : v.md, v.exp_enc);
    sbq.push_back('{id: v.exp_enc, data: d});
    @(negedge clk);
    if (v.exp_enc) req_enc = 0;
    else req_dec = 0;
    chk("exp_base", 64'(exp_base), 64'(v.exp_enc ? v.me : v.md));
    chk("enc_dec_sel", 64'(encrypt_decrypt), 64'(v.exp_enc));
    chk("exp_rst_c1", 64'(exp_reset), 1);
    chk("no_gnt_busy", 64'({gnt_enc, gnt_dec}), 0);
    @(negedge clk);
    chk("exp_rst_c2", 64'(exp_reset), 1);
    @(negedge clk);
    chk("run_exp_rst", 64'(exp_reset), 0);
    repeat (v.lat - 1) @(negedge clk);
    exp_finish = 1;
    exp_result = (exp_base * 32'd3) ^ (encrypt_decrypt ? KE : KD);
    @(negedge clk);
    exp_finish = 0;
    chk("rsp_valid_set", 64'(rsp_valid), 1);
    for (int i = 0; i < v.hold; i++) begin
      req_dec = 1;
      #1;
      chk("hold_no_gnt", 64'({gnt_enc, gnt_dec}), 0);
      chk("hold_data", 64'(rsp_data), 64'(d));
      chk("hold_valid", 64'(rsp_valid), 1);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    req_enc = 0;
    req_dec = 0;
    chk("rsp_valid_clr", 64'(rsp_valid), 0);
    chk("back_ready", 64'({key_ready, busy}), 64'd2);
  endtask

  initial begin
    int low;
    bit got;
    tbl[0] = '{1, 0, 16'h0005, 16'h0000, 3, 0, 1};
    tbl[1] = '{0, 1, 16'h0000, 16'h1234, 1, 0, 0};
    tbl[2] = '{1, 1, 16'h0011, 16'h0022, 2, 0, 1};
    tbl[3] = '{1, 1, 16'h0033, 16'h0044, 2, 0, 0};
    tbl[4] = '{1, 1, 16'h0055, 16'h0066, 2, 0, 1};
    tbl[5] = '{1, 0, 16'h0ABC, 16'h0000, 4, 5, 1};
    tbl[6] = '{0, 1, 16'h0000, 16'hFFFF, 1, 0, 0};
    tbl[7] = '{1, 0, 16'hFFFF, 16'h0000, 6, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({key_ready, busy, timeout_err, rsp_valid}), 0);
    chk("rst_resets", 64'({inv_reset, exp_reset}), 64'd3);
    chk("rst_base", 64'(exp_base), 0);
    chk("rst_sel", 64'({encrypt_decrypt, rsp_id}), 0);
    reset = 1;

    dut_keygen(10);
    foreach (tbl[i]) do_job(tbl[i]);
    chk("sb_drained", 64'(sbq.size()), 0);

    @(negedge clk) t_key_start = 1;
    @(negedge clk) t_key_start = 0;
    low = 0;
    for (int i = 0; i < 30 && !t_timeout_err; i++) begin
      @(negedge clk);
      if (!t_inv_reset) low++;
    end
    chk("kg_timeout_cycles", 64'(low), 8);
    chk("kg_timeout_err", 64'(t_timeout_err), 1);
    chk("kg_timeout_nokey", 64'({t_key_ready, t_busy, t_inv_reset}), 1);

    @(negedge clk) t_key_start = 1;
    @(negedge clk) t_key_start = 0;
    chk("err_clear_keyrst", 64'(t_timeout_err), 0);
    repeat (3) @(negedge clk);
    t_inv_finish = 1;
    @(negedge clk) t_inv_finish = 0;
    chk("t_key_ready", 64'(t_key_ready), 1);

    t_req_enc = 1;
    t_req_dec = 1;
    #1 chk("first_rr_enc", 64'({t_gnt_enc, t_gnt_dec}), 64'd2);
    @(negedge clk) t_req_enc = 0;
    @(negedge clk);
    low = 0;
    for (int i = 0; i < 30 && !t_timeout_err; i++) begin
      @(negedge clk);
      if (!t_exp_reset) low++;
    end
    chk("run_timeout_cycles", 64'(low), 8);
    chk("run_timeout_err", 64'(t_timeout_err), 1);
    chk("run_timeout_ready", 64'({t_key_ready, t_rsp_valid}), 64'd2);
    #1 chk("grant_after_tmo", 64'({t_gnt_enc, t_gnt_dec}), 64'd1);
    @(negedge clk) t_req_dec = 0;

    @(negedge clk);
    req_enc = 1;
    enc_msg = 16'h0077;
    wait_gnt(got);
    chk("mid_grant_seen", 64'(got), 1);
    @(negedge clk) req_enc = 0;
    repeat (2) @(negedge clk);
    chk("mid_in_run", 64'(exp_reset), 0);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_inv", 64'({inv_reset, exp_reset}), 64'd3);
    chk("mid_rst_outs", 64'({key_ready, rsp_valid, busy}), 0);
    chk("mid_rst_base", 64'(exp_base), 0);
    reset = 1;
    exp_finish = 1;
    exp_result = 32'h0000_0ABC;
    @(negedge clk) exp_finish = 0;
    repeat (3) @(negedge clk);
    chk("mid_no_rsp", 64'({rsp_valid, key_ready}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

endmodule

// File: doc/rsa_job_sequencer.md
RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 256, giving the bit width of p/q and of plaintext/ciphertext request operands.
REQ-002 The block SHALL have parameter TIMEOUT, default 65535, giving the maximum wait in cycles for any engine finish.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
  clk  in  1  single system clock, all logic on rising edge
  reset  in  1  synchronous, active-low block reset
  key_start  in  1  pulse; (re)generate keys e/d
  key_ready  out  1  keys valid, jobs accepted
  req_enc  in  1  encrypt request, held until granted
  enc_msg  in  WIDTH  encrypt operand
  gnt_enc  out  1  one-cycle accept of req_enc
  req_dec  in  1  decrypt request, held until granted
  dec_msg  in  WIDTH  decrypt operand
  gnt_dec  out  1  one-cycle accept of req_dec
  inv_reset  out  1  active-high reset/start to key inverter
  inv_finish  in  1  key inverter done
  exp_reset  out  1  active-high reset/start to mod-exp engine
  exp_finish  in  1  mod-exp engine done
  exp_result  in  2*WIDTH  mod-exp result
  exp_base  out  2*WIDTH  operand to mod-exp engine
  encrypt_decrypt  out  1  exponent select, 1=e, 0=d
  rsp_valid  out  1  result available
  rsp_id  out  1  result owner, 1=encrypt, 0=decrypt
  rsp_data  out  2*WIDTH  result value
  rsp_ready  in  1  consumer accepts result
  busy  out  1  state is not NOKEY and not READY
  timeout_err  out  1  sticky engine-timeout flag

Function
REQ-004 The block SHALL implement states NOKEY, KEY_RST, KEYGEN, READY, EXP_RST, RUN, RESP.
REQ-005 NOKEY: inv_reset=1, exp_reset=1; key_start -> KEY_RST.
REQ-006 KEY_RST: exactly 1 cycle with inv_reset=1, clear timeout counter; -> KEYGEN.
REQ-007 KEYGEN: inv_reset=0, exp_reset=1; inv_finish -> READY; counter reaching TIMEOUT -> set timeout_err and go to NOKEY.
REQ-008 key_ready SHALL be 1 only in READY, EXP_RST, RUN and RESP.
REQ-009 READY: key_start has priority over requests and goes to KEY_RST; otherwise any request is granted.
REQ-010 Arbitration SHALL be round-robin between requesters: when only one requests, grant it; when both request, grant the one not granted last; first grant after reset favours enc.
REQ-011 On grant, the block SHALL pulse gnt_x for 1 cycle, latch the zero-extended msg into exp_base, set encrypt_decrypt (enc=1, dec=0), latch rsp_id, and go to EXP_RST.
REQ-012 exp_base and encrypt_decrypt SHALL stay stable from the grant until the next grant.
REQ-013 EXP_RST: exp_reset=1 for exactly 2 cycles, covering the engine's one-cycle input register stage; -> RUN.
REQ-014 RUN: exp_reset=0; exp_finish -> latch exp_result into rsp_data, set rsp_valid=1, -> RESP; counter reaching TIMEOUT -> set timeout_err, no response, -> READY.
REQ-015 RESP: rsp_valid, rsp_data and rsp_id SHALL be held until rsp_ready=1; handshake cycle -> rsp_valid=0 next cycle, -> READY.
REQ-016 The timeout counter SHALL count cycles in KEYGEN/RUN, clear on entry to each, and saturate (no wrap).
REQ-017 key_start outside NOKEY/READY SHALL be ignored; requests outside READY SHALL NOT be granted.
REQ-018 gnt_enc and gnt_dec SHALL never both be 1.
REQ-019 timeout_err SHALL clear only on reset or on entry to KEY_RST.
REQ-020 exp_finish outside RUN and inv_finish outside KEYGEN SHALL be ignored.

Reset
REQ-021 reset=0 at a clock edge SHALL force NOKEY from any state, including mid-job, with: inv_reset=1, exp_reset=1, all gnt/rsp_valid/key_ready/busy/timeout_err=0, exp_base=0, rsp_data=0, rsp_id=0, encrypt_decrypt=0, counter=0, round-robin pointer favouring enc.
REQ-022 An in-flight job SHALL be discarded on reset, with no response.

Verification
REQ-023 key_start pulse, inv_finish 10 cycles later -> inv_reset low for exactly 10 cycles (KEYGEN), key_ready=1 on the following cycle.
REQ-024 req_enc with enc_msg=0x5 -> gnt_enc 1 cycle, exp_base=0x5, encrypt_decrypt=1, exp_reset high 2 cycles; exp_finish with exp_result=0xABC -> rsp_valid=1, rsp_id=1, rsp_data=0xABC held until rsp_ready.
REQ-025 req_enc and req_dec both held for 3 jobs -> grant order enc, dec, enc.
REQ-026 TIMEOUT=8, no exp_finish -> timeout_err=1 after 8 RUN cycles, no rsp_valid, return to READY, next request is granted.
REQ-027 reset=0 during RUN -> next cycle in NOKEY with inv_reset=1, key_ready=0, rsp_valid=0; a later exp_finish produces no response.
REQ-028 rsp_ready held 0 for 5 cycles in RESP with req_dec asserted -> rsp_data stable, no gnt_dec until after the handshake.
